// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// start/a/b flow from requester to subtractor; busy/done/diff/borrow flow back.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    // Handshake: start is only looked at while idle; the operands are captured on the
    // accepting edge, and done pulses for one cycle once diff/borrow hold the new result.
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// with a registered borrow. One operation takes WIDTH+2 cycles from accept to idle.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_subtractor_if.slave     bus,
    output logic [1:0]             dbg_state_o
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, res_q, diff_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               br_q, borrow_q;

    logic               a0, b0, d_bit, br_next, last_bit, accept;
    logic [WIDTH-1:0]   res_next;

    assign a0       = a_sh_q[0];
    assign b0       = b_sh_q[0];
    assign d_bit    = a0 ^ b0 ^ br_q;
    assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    assign res_next = {d_bit, res_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = (state_q == S_IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_SHIFT;
            S_SHIFT: if (last_bit)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == S_SHIFT);
        bus.done = (state_q == S_DONE);
    end

    // diff/borrow only move on the completing edge so they stay valid through the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh_q <= bus.a;
            b_sh_q <= bus.b;
            br_q   <= 1'b0;
            cnt_q  <= '0;
        end else if (state_q == S_SHIFT) begin
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q >> 1;
            res_q  <= res_next;
            br_q   <= br_next;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                diff_q   <= res_next;
                borrow_q <= br_next;
            end
        end
    end

    assign bus.diff    = diff_q;
    assign bus.borrow  = borrow_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table, hand-written corner sequences
// and random traffic checked every cycle against a cycle-level reference model.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: an op occupies WIDTH+2 edges from accept; result shows in the last-but-one
  logic [W:0]   exp_q[$];
  int           left = 0;
  logic [W-1:0] m_diff = '0;
  logic         m_borrow = 1'b0;
  int           n_acc = 0;
  int           n_done = 0;

  initial begin
    logic [W-1:0] ma, mb;
    logic [W:0]   r;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        left = 0;
        m_diff = '0;
        m_borrow = 1'b0;
        exp_q.delete();
      end else if (left == 0) begin
        if (bus.start) begin
          ma = bus.a;
          mb = bus.b;
          exp_q.push_back({ma < mb, W'(ma - mb)});
          left = W + 1;
          n_acc++;
        end
      end else begin
        left--;
        if (left == 1 && exp_q.size() > 0) begin
          r = exp_q.pop_front();
          m_diff = r[W-1:0];
          m_borrow = r[W];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // per-cycle scoreboard: busy, done, diff, borrow against the model
  initial begin
    logic [W+2:0] got_v, exp_v;
    forever begin
      @(negedge clk);
      got_v = {bus.busy, bus.done, bus.borrow, bus.diff};
      exp_v = {(left >= 2), (left == 1), m_borrow, m_diff};
      chk("cycle busy/done/borrow/diff", 32'(got_v), 32'(exp_v));
      if (bus.busy && bus.done) chk("busy_and_done", 32'd1, 32'd0);
      if (bus.done) n_done++;
    end
  end

  // driver tasks
  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    bus.start = st;
    bus.a = a;
    bus.b = b;
  endtask

  task automatic wait_done(output bit ok, output int busy_cnt);
    ok = 0;
    busy_cnt = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int bc;
    drive(1'b1, v.a, v.b);
    drive(1'b0, W'($urandom), W'($urandom));
    wait_done(ok, bc);
    if (ok) begin
      chk("vec_diff", 32'(bus.diff), 32'(v.exp_diff));
      chk("vec_borrow", 32'(bus.borrow), 32'(v.exp_borrow));
      chk("vec_busy_cycles", 32'(bc), 32'(W));
    end
  endtask

  vec_t vecs[5];

  initial begin
    bit ok;
    int bc, dcnt, start_done, start_acc, cycles;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({bus.busy, bus.done, bus.borrow, bus.diff}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // starts during busy and during the done cycle are ignored
    start_done = n_done;
    drive(1'b1, 8'hFF, 8'h01);
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b1, 8'h00, 8'h55);
    drive(1'b0, 8'h00, 8'h55);
    wait_done(ok, bc);
    if (ok) begin
      chk("ignored_diff", 32'(bus.diff), 32'h0000_00FE);
      chk("ignored_borrow", 32'(bus.borrow), 32'd0);
    end
    bus.start = 1'b1;
    bus.a = 8'h00;
    bus.b = 8'h55;
    drive(1'b0, 8'h00, 8'h00);
    repeat (15) @(negedge clk);
    chk("ignored_single_done", 32'(n_done - start_done), 32'd1);

    // start held high: one op per WIDTH+2 cycles
    dcnt = 0;
    drive(1'b1, 8'h09, 8'h03);
    for (int i = 0; i < 3 * (W + 2); i++) begin
      @(negedge clk);
      if (bus.done) begin
        dcnt++;
        chk("held_diff", 32'(bus.diff), 32'h06);
      end
    end
    bus.start = 1'b0;
    chk("held_done_count", 32'(dcnt), 32'd3);
    repeat (W + 4) @(posedge clk);

    // asynchronous reset mid-SHIFT
    drive(1'b1, 8'h33, 8'h11);
    drive(1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({bus.busy, bus.done, bus.borrow, bus.diff}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec('{8'h33, 8'h11, 8'h22, 1'b0});

    // random traffic
    start_done = n_done;
    start_acc = n_acc;
    cycles = 0;
    while ((n_acc - start_acc) < 1000 && cycles < 20000) begin
      drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom));
      cycles++;
    end
    drive(1'b0, 8'h00, 8'h00);
    repeat (W + 4) @(posedge clk);
    chk("random_ops_accepted", 32'((n_acc - start_acc) >= 1000), 32'd1);
    chk("random_done_eq_accept", 32'(n_done - start_done), 32'(n_acc - start_acc));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
